// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Decode-stage hazard controller. It keeps a saturating pending-write count
//   per architectural register, stalls the decoder while a source is still
//   being produced (or a destination count is full), and blocks issue while
//   the pipeline drains after a flush.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   dec_valid            decoder holds a uop
//   dec_rs1/rs2/rd       decoded register addresses, each with a _valid qualifier
//   system_stall         global stall, suppresses issue only
//   wb_valid, wb_rd      writeback completion
//   flush                single-cycle flush request
//   source_not_ready     (comb) decoder must hold and re-present the uop
//   issue_fire           (comb) uop accepted this cycle
//   drain_busy           (reg)  high while draining after a flush
//   inflight_total       (reg)  sum of all pending-write counters
//   wb_err               (reg, sticky) writeback to a register with nothing pending
module issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic [ADDR_W-1:0] dec_rd,
    input  logic              dec_rs1_valid,
    input  logic              dec_rs2_valid,
    input  logic              dec_rd_valid,
    input  logic              system_stall,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              flush,
    output logic              source_not_ready,
    output logic              issue_fire,
    output logic              drain_busy,
    output logic [6:0]        inflight_total,
    output logic              wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {RUN, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt [NUM_REGS];

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic             hz1, hz2, hzd;
    logic [NUM_REGS-1:0] inc_vec, dec_vec;
    logic             total_inc, total_dec;

    // Saturating increment; the destination hazard already prevents issue
    // into a full counter, this keeps the counter from ever wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // Counter lookup; x0 and out-of-range addresses always read as 0.
    always_comb begin
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        cnt_wb  = '0;
        if (dec_rs1 != '0 && int'(dec_rs1) < NUM_REGS) cnt_rs1 = cnt[dec_rs1];
        if (dec_rs2 != '0 && int'(dec_rs2) < NUM_REGS) cnt_rs2 = cnt[dec_rs2];
        if (dec_rd  != '0 && int'(dec_rd)  < NUM_REGS) cnt_rd  = cnt[dec_rd];
        if (wb_rd   != '0 && int'(wb_rd)   < NUM_REGS) cnt_wb  = cnt[wb_rd];
    end

    // A writeback retiring the last pending write of a source releases the
    // dependent uop in the same cycle.
    always_comb begin
        hz1 = dec_rs1_valid && (cnt_rs1 != '0) &&
              !(wb_valid && wb_rd == dec_rs1 && cnt_rs1 == CNT_W'(1));
        hz2 = dec_rs2_valid && (cnt_rs2 != '0) &&
              !(wb_valid && wb_rd == dec_rs2 && cnt_rs2 == CNT_W'(1));
        hzd = dec_rd_valid && (cnt_rd == CNT_MAX);
    end

    assign source_not_ready = dec_valid && (hz1 || hz2 || hzd || state == DRAIN);
    assign issue_fire       = dec_valid && !source_not_ready && !system_stall;
    assign drain_busy       = (state == DRAIN);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_vec[r] = issue_fire && dec_rd_valid && (dec_rd == ADDR_W'(r));
            dec_vec[r] = wb_valid && (wb_rd == ADDR_W'(r)) && (cnt[r] != '0);
        end
        total_inc = |inc_vec;
        total_dec = |dec_vec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            state          <= RUN;
            inflight_total <= '0;
            wb_err         <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])      cnt[r] <= sat_inc(cnt[r]);
                else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= sat_dec(cnt[r]);
            end

            if (total_inc && !total_dec)      inflight_total <= inflight_total + 7'd1;
            else if (total_dec && !total_inc) inflight_total <= inflight_total - 7'd1;

            if (wb_valid && wb_rd != '0 && cnt_wb == '0) wb_err <= 1'b1;

            // Leave DRAIN the cycle after the registered total reads zero;
            // a flush while already draining changes nothing.
            case (state)
                RUN:     if (flush) state <= DRAIN;
                DRAIN:   if (inflight_total == 7'd0) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
